inst_fifo_fetcher: RTL and testbench

INST_FIFO_FETCHER -- requirements
Module: inst_fifo_fetcher

---
 rtl/inst_fifo_fetcher.sv | 134 +++++++++++++
 tb/tb_inst_fifo_fetcher.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fifo_fetcher.sv
// inst_fifo_fetcher
//   Pulls instruction words from an upstream instruction FIFO into a small
//   in-order buffer of DEPTH entries. Each buffered word carries a sequence tag.
//   The tag comes from a free-running counter, which a flush leaves untouched
//   and a reset clears.
//   Optional build macro: INST_FETCH_NOP_FILTER_EN. When it is defined, the
//   canonical NOP (addi x0,x0,0 = 32'h00000013) is still read from the FIFO,
//   but it is dropped instead of buffered and does not consume a tag.
module inst_fifo_fetcher #(
   parameter int DEPTH = 4,
   parameter int SEQ_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             fetch_en,
   input  logic             flush,
   output logic             inst_fifo_rd,
   input  logic [31:0]      inst_fifo_rdata,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_inst,
   output logic [SEQ_W-1:0] out_seq,
   output logic [1:0]       fetch_state
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0]      inst;
      logic [SEQ_W-1:0] seq;
   } entry_t;

   state_t                 state, state_nxt;
   entry_t [DEPTH-1:0]     mem;
   logic   [PTR_W-1:0]     wr_ptr, rd_ptr;
   logic   [CNT_W-1:0]     count;
   logic   [SEQ_W-1:0]     seq_next;
   logic                   is_nop;
   logic                   push, pop;

`ifdef INST_FETCH_NOP_FILTER_EN
   assign is_nop = (inst_fifo_rdata == 32'h0000_0013);
`else
   assign is_nop = 1'b0;
`endif

   // A filtered NOP is still read from the FIFO, so the strobe is unaffected;
   // only the write into the buffer is suppressed.
   assign push = inst_fifo_rd & ~is_nop;
   assign pop  = out_valid & out_ready;

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; flush overrides every other transition.
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = S_FLUSH;
      end else begin
         case (state)
            S_IDLE:  if (fetch_en)  state_nxt = S_RUN;
            S_RUN:   if (!fetch_en) state_nxt = S_IDLE;
            S_FLUSH: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // FSM outputs. A read is allowed into a full buffer when the head leaves
   // in the same cycle.
   always_comb begin
      fetch_state  = state;
      inst_fifo_rd = 1'b0;
      if (state == S_RUN && fetch_en && !flush && (count < FULL || pop))
         inst_fifo_rd = 1'b1;
   end

   // Occupancy and pointers. A flush clears them and ignores any concurrent
   // traffic; push+pop leaves count alone even when the buffer is full.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sequence tag counter; it survives flush so tags stay unique across flushes.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)     seq_next <= '0;
      else if (push) seq_next <= seq_next + 1'b1;
   end

   // Entry storage. It is cleared on reset so the head reads zero while in reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr] <= '{inst: inst_fifo_rdata, seq: seq_next};
      end
   end

   // Head presentation. A written entry is not bypassed to the output.
   always_comb begin
      out_valid = (count != '0);
      out_inst  = mem[rd_ptr].inst;
      out_seq   = mem[rd_ptr].seq;
   end

endmodule

// File: tb/tb_inst_fifo_fetcher.sv
// Scoreboard bench for inst_fifo_fetcher. Words read from the FIFO are pushed,
// together with a tag model, into an expected queue. The bench pops from that
// queue whenever the DUT presents a head entry that the consumer accepts.
module tb_inst_fifo_fetcher;
   localparam int DEPTH = 4;
   localparam int SEQ_W = 16;
`ifdef INST_FETCH_NOP_FILTER_EN
   localparam bit FILTER = 1'b1;
`else
   localparam bit FILTER = 1'b0;
`endif

   typedef struct packed {
      logic [31:0]      inst;
      logic [SEQ_W-1:0] seq;
   } exp_t;

   logic             clock = 1'b0;
   logic             reset, fetch_en, flush, out_ready;
   logic             inst_fifo_rd, out_valid;
   logic [31:0]      inst_fifo_rdata, out_inst;
   logic [SEQ_W-1:0] out_seq;
   logic [1:0]       fetch_state;

   exp_t             q[$];
   logic [31:0]      src[$];
   logic [SEQ_W-1:0] seq_m;
   int               junk;
   int               n_vec = 0;
   int               n_err = 0;

   logic             obs_rd, obs_valid, obs_pop, exp_valid;
   logic [31:0]      obs_inst;
   logic [SEQ_W-1:0] obs_seq;
   logic [1:0]       obs_state;
   exp_t             exp_e;

   inst_fifo_fetcher #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
      .clock           (clock),
      .reset           (reset),
      .fetch_en        (fetch_en),
      .flush           (flush),
      .inst_fifo_rd    (inst_fifo_rd),
      .inst_fifo_rdata (inst_fifo_rdata),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_inst        (out_inst),
      .out_seq         (out_seq),
      .fetch_state     (fetch_state)
   );

   always #5 clock = ~clock;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // One clock cycle. The task samples outputs mid-cycle, updates the
   // expected model and returns 1 time unit after the rising edge.
   task automatic tick();
      inst_fifo_rdata = (src.size() != 0) ? src[0] : (32'h1000_0000 | 32'(junk));
      @(negedge clock);
      obs_rd    = inst_fifo_rd;
      obs_valid = out_valid;
      obs_inst  = out_inst;
      obs_seq   = out_seq;
      obs_state = fetch_state;
      exp_valid = (q.size() != 0);
      obs_pop   = 1'b0;
      if (!flush && out_valid && out_ready && q.size() != 0) begin
         exp_e   = q.pop_front();
         obs_pop = 1'b1;
      end
      if (flush) begin
         q.delete();
      end else if (inst_fifo_rd) begin
         if (src.size() != 0) void'(src.pop_front());
         else junk++;
         if (!(FILTER && inst_fifo_rdata == 32'h0000_0013)) begin
            q.push_back('{inst: inst_fifo_rdata, seq: seq_m});
            seq_m++;
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; fetch_en = 1'b0; flush = 1'b0; out_ready = 1'b0;
      q.delete(); src.delete(); seq_m = '0; junk = 0;
      @(posedge clock); @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      fetch_en = 1'b0; flush = 1'b0; out_ready = 1'b0; inst_fifo_rdata = '0;
      reset = 1'b0;
      #1 reset = 1'b1;
      #2;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
      n_vec++; if (inst_fifo_rd !== 1'b0) begin n_err++; $display("FAIL reset_rd got %0b want 0", inst_fifo_rd); end
      n_vec++; if (fetch_state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", fetch_state); end
      n_vec++; if (out_inst !== 32'h0) begin n_err++; $display("FAIL reset_out_inst got %h want 0", out_inst); end
      n_vec++; if (out_seq !== '0) begin n_err++; $display("FAIL reset_out_seq got %h want 0", out_seq); end
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic test_basic();
      int pops;
      pops = 0;
      do_reset();
      src = '{32'hA0, 32'hA1, 32'hA2};
      fetch_en = 1'b1; out_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (src.size() == 0) fetch_en = 1'b0;
         tick();
         n_vec++; if (obs_valid !== exp_valid) begin n_err++; $display("FAIL basic_valid c=%0d got %0b want %0b", c, obs_valid, exp_valid); end
         if (obs_pop) begin
            pops++;
            n_vec++;
            if (obs_inst !== exp_e.inst || obs_seq !== exp_e.seq) begin
               n_err++; $display("FAIL basic_pop got %h/%0d want %h/%0d", obs_inst, obs_seq, exp_e.inst, exp_e.seq);
            end
         end
         if (c == 0) begin n_vec++; if (obs_rd !== 1'b0) begin n_err++; $display("FAIL basic_rd_c0 got %0b want 0", obs_rd); end end
         if (c == 1) begin n_vec++; if (obs_rd !== 1'b1) begin n_err++; $display("FAIL basic_rd_c1 got %0b want 1", obs_rd); end end
      end
      n_vec++; if (pops !== 3) begin n_err++; $display("FAIL basic_pops got %0d want 3", pops); end
   endtask

   task automatic test_backpressure();
      int reads;
      reads = 0;
      do_reset();
      src = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5, 32'hB6, 32'hB7};
      fetch_en = 1'b1; out_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (obs_rd) reads++;
         n_vec++; if (obs_valid !== exp_valid) begin n_err++; $display("FAIL bp_valid c=%0d got %0b want %0b", c, obs_valid, exp_valid); end
      end
      n_vec++; if (reads !== 4) begin n_err++; $display("FAIL bp_reads got %0d want 4", reads); end
      n_vec++; if (obs_rd !== 1'b0) begin n_err++; $display("FAIL bp_rd_full got %0b want 0", obs_rd); end
      n_vec++; if (dut.count !== 3'd4) begin n_err++; $display("FAIL bp_count_full got %0d want 4", dut.count); end
      out_ready = 1'b1;
      tick();
      n_vec++; if (obs_rd !== 1'b1) begin n_err++; $display("FAIL bp_rd_reassert got %0b want 1", obs_rd); end
      n_vec++; if (dut.count !== 3'd4) begin n_err++; $display("FAIL bp_count_hold got %0d want 4", dut.count); end
      if (obs_pop) begin
         n_vec++;
         if (obs_inst !== exp_e.inst || obs_seq !== exp_e.seq) begin
            n_err++; $display("FAIL bp_pop got %h/%0d want %h/%0d", obs_inst, obs_seq, exp_e.inst, exp_e.seq);
         end
      end
      for (int c = 0; c < 16; c++) begin
         if (src.size() == 0) fetch_en = 1'b0;
         tick();
         n_vec++; if (obs_valid !== exp_valid) begin n_err++; $display("FAIL bp_drain_valid c=%0d got %0b want %0b", c, obs_valid, exp_valid); end
         if (obs_pop) begin
            n_vec++;
            if (obs_inst !== exp_e.inst || obs_seq !== exp_e.seq) begin
               n_err++; $display("FAIL bp_pop got %h/%0d want %h/%0d", obs_inst, obs_seq, exp_e.inst, exp_e.seq);
            end
         end
      end
      n_vec++; if (q.size() !== 0) begin n_err++; $display("FAIL bp_left got %0d entries want 0", q.size()); end
   endtask

   task automatic test_flush();
      int first_seq;
      first_seq = -1;
      do_reset();
      src = '{32'hC0, 32'hC1, 32'hC2};
      fetch_en = 1'b1; out_ready = 1'b0;
      for (int c = 0; c < 10 && src.size() != 0; c++) tick();
      fetch_en = 1'b0;
      tick();
      n_vec++; if (dut.count !== 3'd3) begin n_err++; $display("FAIL flush_pre_count got %0d want 3", dut.count); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      n_vec++; if (obs_state !== 2'd2) begin n_err++; $display("FAIL flush_state got %0d want 2", obs_state); end
      n_vec++; if (obs_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %0b want 0", obs_valid); end
      tick();
      n_vec++; if (obs_state !== 2'd0) begin n_err++; $display("FAIL flush_idle got %0d want 0", obs_state); end
      src = '{32'hC8};
      fetch_en = 1'b1; out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (src.size() == 0) fetch_en = 1'b0;
         tick();
         n_vec++; if (obs_valid !== exp_valid) begin n_err++; $display("FAIL flush_re_valid c=%0d got %0b want %0b", c, obs_valid, exp_valid); end
         if (obs_pop) begin
            if (first_seq < 0) first_seq = int'(obs_seq);
            n_vec++;
            if (obs_inst !== exp_e.inst || obs_seq !== exp_e.seq) begin
               n_err++; $display("FAIL flush_pop got %h/%0d want %h/%0d", obs_inst, obs_seq, exp_e.inst, exp_e.seq);
            end
         end
      end
      n_vec++; if (first_seq !== 3) begin n_err++; $display("FAIL flush_seq got %0d want 3", first_seq); end
   endtask

   task automatic test_seq_wrap();
      logic             saw, have_prev;
      logic [SEQ_W-1:0] prev;
      saw = 1'b0; have_prev = 1'b0; prev = '0;
      do_reset();
      fetch_en = 1'b1; out_ready = 1'b1;
      for (int c = 0; c < 65545; c++) begin
         tick();
         n_vec++; if (obs_valid !== exp_valid) begin n_err++; $display("FAIL wrap_valid c=%0d got %0b want %0b", c, obs_valid, exp_valid); end
         if (obs_pop) begin
            n_vec++;
            if (obs_inst !== exp_e.inst || obs_seq !== exp_e.seq) begin
               n_err++; $display("FAIL wrap_pop got %h/%0d want %h/%0d", obs_inst, obs_seq, exp_e.inst, exp_e.seq);
            end
            if (have_prev && prev == 16'hFFFF && obs_seq == 16'h0000) saw = 1'b1;
            prev = obs_seq; have_prev = 1'b1;
         end
      end
      fetch_en = 1'b0;
      n_vec++; if (saw !== 1'b1) begin n_err++; $display("FAIL wrap_seen got %0b want 1", saw); end
   endtask

   task automatic test_nop();
      int          pops;
      logic [31:0] first_inst;
      logic [SEQ_W-1:0] first_seq;
      pops = 0; first_inst = 'x; first_seq = 'x;
      do_reset();
      src = '{32'h0000_0013, 32'hB0};
      fetch_en = 1'b1; out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (src.size() == 0) fetch_en = 1'b0;
         tick();
         n_vec++; if (obs_valid !== exp_valid) begin n_err++; $display("FAIL nop_valid c=%0d got %0b want %0b", c, obs_valid, exp_valid); end
         if (obs_pop) begin
            if (pops == 0) begin first_inst = obs_inst; first_seq = obs_seq; end
            pops++;
            n_vec++;
            if (obs_inst !== exp_e.inst || obs_seq !== exp_e.seq) begin
               n_err++; $display("FAIL nop_pop got %h/%0d want %h/%0d", obs_inst, obs_seq, exp_e.inst, exp_e.seq);
            end
         end
      end
      n_vec++; if (pops !== (FILTER ? 1 : 2)) begin n_err++; $display("FAIL nop_pops got %0d want %0d", pops, FILTER ? 1 : 2); end
      n_vec++; if (first_inst !== (FILTER ? 32'hB0 : 32'h13)) begin n_err++; $display("FAIL nop_first_inst got %h", first_inst); end
      n_vec++; if (first_seq !== '0) begin n_err++; $display("FAIL nop_first_seq got %0d want 0", first_seq); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      src = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
      fetch_en = 1'b1; out_ready = 1'b0;
      for (int c = 0; c < 3; c++) tick();
      n_vec++; if (out_valid !== 1'b1 || inst_fifo_rd !== 1'b1) begin
         n_err++; $display("FAIL rmid_pre got valid=%0b rd=%0b want 1/1", out_valid, inst_fifo_rd);
      end
      #2 reset = 1'b1;
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid got %0b want 0", out_valid); end
      n_vec++; if (inst_fifo_rd !== 1'b0) begin n_err++; $display("FAIL rmid_rd got %0b want 0", inst_fifo_rd); end
      n_vec++; if (fetch_state !== 2'd0) begin n_err++; $display("FAIL rmid_state got %0d want 0", fetch_state); end
      fetch_en = 1'b0; q.delete(); src.delete(); seq_m = '0;
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_flush();
      test_nop();
      test_reset_mid();
      test_seq_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
